// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, HI/LO busy tracking and stall counter
// Register hazards stall when a producer's result arrives later than the consumer needs it.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic        D_use_rs,
  input  logic        D_use_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_op,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t   state, state_next;
  logic [3:0]  md_cnt, md_cnt_next;
  logic        md_done_next;
  logic        stall_rs, stall_rt, stall_md;

  // Register $0 never carries a real dependency.
  assign stall_rs = D_use_rs && (D_rs != 5'd0) &&
                    (((E_wa == D_rs) && (E_tnew > D_tuse_rs)) ||
                     ((M_wa == D_rs) && (M_tnew > D_tuse_rs)));

  assign stall_rt = D_use_rt && (D_rt != 5'd0) &&
                    (((E_wa == D_rt) && (E_tnew > D_tuse_rt)) ||
                     ((M_wa == D_rt) && (M_tnew > D_tuse_rt)));

  assign md_busy  = (state == BUSY);
  assign stall_md = D_is_md && (md_busy || E_md_start);
  assign stall    = stall_rs || stall_rt || stall_md;
  assign flush_E  = stall;

  always_comb begin
    state_next   = state;
    md_cnt_next  = md_cnt;
    md_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (E_md_start) begin
          state_next  = BUSY;
          md_cnt_next = E_md_op ? 4'd10 : 4'd5;
        end
      end
      BUSY: begin
        // A start seen here is deliberately ignored: no reload, no extension.
        if (md_cnt == 4'd1) begin
          state_next   = IDLE;
          md_cnt_next  = 4'd0;
          md_done_next = 1'b1;
        end else begin
          md_cnt_next = md_cnt - 4'd1;
        end
      end
      default: begin
        state_next  = IDLE;
        md_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      md_cnt  <= 4'd0;
      md_done <= 1'b0;
    end else begin
      state   <= state_next;
      md_cnt  <= md_cnt_next;
      md_done <= md_done_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector and sequence bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic        D_use_rs, D_use_rt, D_is_md, E_md_start, E_md_op;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        stall, flush_E, md_busy, md_done;
  logic [31:0] stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
    .E_wa(E_wa), .M_wa(M_wa), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_op(E_md_op),
    .stall(stall), .flush_E(flush_E), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       is_md;
    logic [4:0] e_wa, m_wa;
    logic [1:0] e_tnew, m_tnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    D_rs = v.rs; D_rt = v.rt; D_use_rs = v.use_rs; D_use_rt = v.use_rt;
    D_tuse_rs = v.tuse_rs; D_tuse_rt = v.tuse_rt; D_is_md = v.is_md;
    E_wa = v.e_wa; M_wa = v.m_wa; E_tnew = v.e_tnew; M_tnew = v.m_tnew;
  endtask

  task automatic quiet();
    D_rs = 0; D_rt = 0; D_use_rs = 0; D_use_rt = 0; D_tuse_rs = 0; D_tuse_rt = 0;
    D_is_md = 0; E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
    E_md_start = 0; E_md_op = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    //            rs  rt  urs urt trs trt md  ewa mwa etn mtn exp
    vecs.push_back('{5'd8, 5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd8, 5'd0, 2'd2, 2'd0, 1});
    vecs.push_back('{5'd8, 5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd0, 5'd8, 2'd2, 2'd1, 1});
    vecs.push_back('{5'd8, 5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd0, 5'd8, 2'd2, 2'd0, 0});
    vecs.push_back('{5'd0, 5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd0, 5'd0, 2'd2, 2'd0, 0});
    vecs.push_back('{5'd8, 5'd0, 0, 0, 2'd0, 2'd0, 0, 5'd8, 5'd0, 2'd2, 2'd0, 0});
    vecs.push_back('{5'd0, 5'd5, 0, 1, 2'd0, 2'd1, 0, 5'd5, 5'd0, 2'd1, 2'd0, 0});
    vecs.push_back('{5'd0, 5'd5, 0, 1, 2'd0, 2'd1, 0, 5'd5, 5'd0, 2'd2, 2'd0, 1});
    vecs.push_back('{5'd0, 5'd5, 0, 1, 2'd0, 2'd0, 0, 5'd0, 5'd5, 2'd0, 2'd1, 1});
    vecs.push_back('{5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 1, 5'd0, 5'd0, 2'd0, 2'd0, 0});
    vecs.push_back('{5'd3, 5'd0, 1, 0, 2'd2, 2'd0, 0, 5'd3, 5'd0, 2'd2, 2'd0, 0});
    vecs.push_back('{5'd3, 5'd0, 1, 0, 2'd1, 2'd0, 0, 5'd0, 5'd3, 2'd0, 2'd2, 1});
    vecs.push_back('{5'd9, 5'd0, 1, 0, 2'd0, 2'd0, 0, 5'd7, 5'd6, 2'd2, 2'd2, 0});

    quiet();
    reset = 1'b0;
    #12;
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_done", {31'd0, md_done}, 32'd0);
    check("reset_cnt", stall_cnt, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_flush", i), {31'd0, flush_E}, {31'd0, vecs[i].exp_stall});
      tick();
    end

    // stall counter: exactly 7 stalled edges
    quiet();
    do_reset();
    apply(vecs[0]);
    repeat (7) tick();
    quiet();
    tick();
    check("stall_cnt_7", stall_cnt, 32'd7);

    // mult: 5 busy cycles, md-class stall throughout
    do_reset();
    D_is_md = 1; E_md_start = 1; E_md_op = 0;
    #1;
    check("mult_stall_start", {31'd0, stall}, 32'd1);
    tick();
    E_md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("mult_busy%0d", i), {31'd0, md_busy}, 32'd1);
      check($sformatf("mult_stall%0d", i), {31'd0, stall}, 32'd1);
      check($sformatf("mult_nodone%0d", i), {31'd0, md_done}, 32'd0);
      tick();
    end
    check("mult_idle", {31'd0, md_busy}, 32'd0);
    check("mult_done", {31'd0, md_done}, 32'd1);
    check("mult_stall_end", {31'd0, stall}, 32'd0);
    // back-to-back start in the done cycle
    E_md_start = 1; E_md_op = 0;
    tick();
    E_md_start = 0;
    check("b2b_busy", {31'd0, md_busy}, 32'd1);
    check("b2b_done_pulse", {31'd0, md_done}, 32'd0);
    repeat (5) tick();
    check("b2b_done", {31'd0, md_done}, 32'd1);
    tick();
    check("b2b_done_clear", {31'd0, md_done}, 32'd0);

    // div with an ignored start at busy cycle 3
    D_is_md = 0;
    E_md_start = 1; E_md_op = 1;
    tick();
    E_md_start = 0;
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("div_busy%0d", i), {31'd0, md_busy}, 32'd1);
      E_md_start = (i == 3);
      E_md_op = 0;
      tick();
    end
    E_md_start = 0;
    check("div_idle", {31'd0, md_busy}, 32'd0);
    check("div_done", {31'd0, md_done}, 32'd1);

    // reset mid-div aborts with no done pulse
    tick();
    E_md_start = 1; E_md_op = 1;
    tick();
    E_md_start = 0;
    repeat (3) tick();
    check("abort_busy_pre", {31'd0, md_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy_async", {31'd0, md_busy}, 32'd0);
    check("abort_done_async", {31'd0, md_done}, 32'd0);
    apply(vecs[0]);
    #1;
    check("reset_stall_comb", {31'd0, stall}, 32'd1);
    check("reset_flush_comb", {31'd0, flush_E}, 32'd1);
    quiet();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("post_abort_done%0d", i), {31'd0, md_done}, 32'd0);
      tick();
    end
    check("post_abort_idle", {31'd0, md_busy}, 32'd0);

    // saturation near the top of the counter
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    apply(vecs[0]);
    tick();
    check("sat_fffe", stall_cnt, 32'hFFFF_FFFE);
    tick();
    check("sat_ffff", stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold1", stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold2", stall_cnt, 32'hFFFF_FFFF);
    quiet();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
